// File: rtl/capture_writer.sv
// capture_writer
//   Arms on request, waits for a trigger, then writes buffer_length I/Q
//   samples to consecutive buffer addresses starting at 0, and parks in
//   DONE until the next arm.
//
//   Optional feature: define CAPTURE_DECIM_EN to keep only one valid sample
//   in decim_factor (counted from the trigger cycle). The default build
//   accepts every valid sample and contains no decimation counter.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   arm            in   request to arm a capture (IDLE/DONE only)
//   trigger        in   starts the capture while ARMED
//   s_axis_tvalid  in   input sample valid
//   i, q           in   signed I/Q samples
//   wr_en          out  registered buffer write strobe
//   wr_addr        out  registered buffer write address
//   wr_data        out  registered {i, q}, I in the MSBs
//   busy           out  high in ARMED or CAPTURE
//   done           out  high in DONE
//   dbg_state      out  raw FSM state register for observation
//
// Handshake: a sample is transferred on any rising edge where s_axis_tvalid
// is high; there is no back-pressure. A sample is accepted when it is valid
// and the FSM is in CAPTURE, or in ARMED with trigger high in the same cycle.
// The write for an accepted sample appears on wr_* exactly one cycle later.
module capture_writer #(
    parameter int buffer_length = 10,
    parameter int index_bits    = 4,
    parameter int i_bits        = 12,
    parameter int q_bits        = 12,
    parameter int decim_factor  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      trigger,
    input  logic                      s_axis_tvalid,
    input  logic signed [i_bits-1:0]  i,
    input  logic signed [q_bits-1:0]  q,
    output logic                      wr_en,
    output logic [index_bits-1:0]     wr_addr,
    output logic [i_bits+q_bits-1:0]  wr_data,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                dbg_state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);
    localparam logic [index_bits-1:0] IDX_ONE  = index_bits'(1);

    if (decim_factor < 1) begin : g_bad_decim
        $error("capture_writer: decim_factor must be at least 1");
    end

    logic [1:0]              state_q, state_d;
    logic [index_bits-1:0]   idx_q, idx_d;
    logic                    wr_en_q;
    logic [index_bits-1:0]   wr_addr_q;
    logic [i_bits+q_bits-1:0] wr_data_q;

    logic trig_now;   // trigger seen while ARMED
    logic in_window;  // valid sample inside the capture window
    logic take;       // sample is accepted and written
    logic last;

    assign trig_now  = (state_q == S_ARMED) && trigger;
    assign in_window = s_axis_tvalid && (trig_now || (state_q == S_CAPTURE));
    assign last      = (idx_q == LAST_IDX);

`ifdef CAPTURE_DECIM_EN
    localparam int DW = (decim_factor > 1) ? $clog2(decim_factor) : 1;
    localparam logic [DW-1:0] DLAST = DW'(decim_factor - 1);
    localparam logic [DW-1:0] DONE_ = DW'(1);

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          dcnt_zero;

    // The trigger cycle restarts the count: its sample is count 0 whatever
    // the counter held from an earlier capture.
    always_comb begin
        dcnt_d    = dcnt_q;
        dcnt_zero = (dcnt_q == '0);
        if (trig_now) begin
            dcnt_zero = 1'b1;
            dcnt_d    = '0;
            if (s_axis_tvalid) begin
                dcnt_d = (DLAST == '0) ? '0 : DONE_;
            end
        end else if ((state_q == S_CAPTURE) && s_axis_tvalid) begin
            dcnt_d = (dcnt_q == DLAST) ? '0 : dcnt_q + DONE_;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    assign take = in_window && dcnt_zero;
`else
    assign take = in_window;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    idx_d   = '0;
                end
            end
            S_ARMED: begin
                // buffer_length of 1 can finish in the trigger cycle itself
                if (trigger) begin
                    state_d = (take && last) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (take && last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // take is only possible in ARMED/CAPTURE, so it never collides with
        // the address clear done on ARMED entry
        if (take) begin
            idx_d = idx_q + IDX_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_en_q <= take;
            // address/data only move with a write, so they hold otherwise
            if (take) begin
                wr_addr_q <= idx_q;
                wr_data_q <= {i, q};
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_capture_writer.sv
module tb_capture_writer;

  localparam int BUF    = 10;
  localparam int AW     = 4;
  localparam int IW     = 12;
  localparam int QW     = 12;
`ifdef CAPTURE_DECIM_EN
  localparam int DECIM  = 4;
`else
  localparam int DECIM  = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                arm = 1'b0;
  logic                trigger = 1'b0;
  logic                s_axis_tvalid = 1'b0;
  logic [IW-1:0]       i = '0;
  logic [QW-1:0]       q = '0;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [IW+QW-1:0]    wr_data;
  logic                busy;
  logic                done;
  logic [1:0]          dbg_state;

  capture_writer #(
    .buffer_length(BUF),
    .index_bits(AW),
    .i_bits(IW),
    .q_bits(QW),
    .decim_factor(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .trigger(trigger),
    .s_axis_tvalid(s_axis_tvalid),
    .i(i),
    .q(q),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [IW+QW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Capture described by its rules: armed/capturing/finished flags, the
  // number of samples written so far and the number of valid samples seen
  // since the trigger (every DECIM-th one, starting with the first, is kept).
  bit               m_armed, m_cap, m_done;
  int               m_n, m_vcount;
  logic             exp_en = 1'b0;
  logic [AW-1:0]    exp_addr = '0;
  logic [IW+QW-1:0] exp_data = '0;

  task automatic model_cycle(input bit r, a, t, v, input logic [IW-1:0] si, input logic [QW-1:0] sq);
    bit idle_or_done, starting, acc;
    if (r) begin
      m_armed = 0; m_cap = 0; m_done = 0; m_n = 0; m_vcount = 0;
      exp_en = 0; exp_addr = '0; exp_data = '0;
      exp_q.delete();
      return;
    end
    idle_or_done = !m_armed && !m_cap;
    starting = m_armed && t;
    acc = 0;
    exp_en = 0;
    if (starting) m_vcount = 0;
    if ((starting || m_cap) && v) begin
      acc = (m_vcount % DECIM) == 0;
      m_vcount++;
    end
    if (starting) begin
      m_armed = 0;
      m_cap = 1;
    end
    if (acc) begin
      exp_en = 1;
      exp_addr = m_n[AW-1:0];
      exp_data = {si, sq};
      exp_q.push_back({si, sq});
      m_n++;
      if (m_n == BUF) begin
        m_cap = 0;
        m_done = 1;
      end
    end
    if (idle_or_done && a) begin
      m_armed = 1;
      m_done = 0;
      m_n = 0;
    end
  endtask

  task automatic check_outputs();
    logic [IW+QW-1:0] head;
    check("wr_en", 32'(wr_en), 32'(exp_en));
    check("wr_addr", 32'(wr_addr), 32'(exp_addr));
    check("wr_data", 32'(wr_data), 32'(exp_data));
    check("busy", 32'(busy), 32'(m_armed || m_cap));
    check("done", 32'(done), 32'(m_done));
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        check("wr_order", 32'(wr_data), 32'(head));
      end else begin
        check("wr_unexpected", 32'(wr_en), 32'(0));
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are checked on the next
  // falling edge after the rising edge that consumed them.
  task automatic step(input bit r, a, t, v, input logic [IW-1:0] si, input logic [QW-1:0] sq);
    rst = r; arm = a; trigger = t; s_axis_tvalid = v; i = si; q = sq;
    model_cycle(r, a, t, v, si, sq);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, '0, '0);
    step(1, 1, 1, 1, 12'h5a5, 12'ha5a);  // reset wins over all inputs
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int exp_writes;
    @(negedge clk);
    do_reset();

    // basic capture: I/Q = (n, -n), n = 0..14, trigger with sample 0
    wr_cnt = 0;
    step(0, 1, 0, 0, '0, '0);
    for (int k = 0; k < 15; k++) step(0, 0, (k == 0), 1, IW'(k), QW'(-k));
    idle_cycles(3);
    exp_writes = (15 + DECIM - 1) / DECIM;
    if (exp_writes > BUF) exp_writes = BUF;
    check("basic_writes", 32'(wr_cnt), 32'(exp_writes));

    // re-capture from DONE with valid toggling 1,0,1,0
    wr_cnt = 0;
    step(0, 1, 0, 0, '0, '0);
    n = 100;
    for (int k = 0; k < 24 * DECIM; k++) begin
      step(0, 0, (k == 0), (k % 2 == 0), IW'(n), QW'(-n));
      n++;
    end
    idle_cycles(2);
    check("gap_writes", 32'(wr_cnt), 32'(BUF));
    check("gap_done", 32'(done), 32'(1));

    // trigger before arm: nothing is written
    do_reset();
    wr_cnt = 0;
    for (int k = 0; k < 4; k++) step(0, 0, 1, 1, IW'(k + 7), QW'(k + 9));
    check("pre_arm_writes", 32'(wr_cnt), 32'(0));
    check("pre_arm_busy", 32'(busy), 32'(0));

    // arm during capture is ignored
    wr_cnt = 0;
    step(0, 1, 0, 0, '0, '0);
    for (int k = 0; k < 14 * DECIM; k++)
      step(0, (k == 3 || k == 6), (k == 0), 1, IW'(k + 300), QW'(k + 600));
    idle_cycles(2);
    check("arm_in_cap_writes", 32'(wr_cnt), 32'(BUF));

    // reset mid-capture after 5 writes, then restart at address 0
    do_reset();
    step(0, 1, 0, 0, '0, '0);
    for (int k = 0; k < 5 * DECIM; k++) step(0, 0, (k == 0), 1, IW'(k + 40), QW'(k + 50));
    step(1, 0, 0, 1, 12'h111, 12'h222);
    check("rst_mid_en", 32'(wr_en), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    idle_cycles(1);
    step(0, 0, 1, 1, 12'h333, 12'h444);  // trigger without new arm: ignored
    step(0, 1, 0, 0, '0, '0);
    step(0, 0, 1, 1, 12'h777, 12'h888);
    check("restart_addr", 32'(wr_addr), 32'(0));
    check("restart_data", 32'(wr_data), 32'(24'h777888));

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           IW'($urandom), QW'($urandom));
    end
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
